// File: rtl/sw_debounce.sv
// Slide-switch conditioning: a 2-FF synchroniser per bit, then an independent
// stability qualifier per bit. A new level is accepted only after it has been
// seen on sync2 for STABLE_CYCLES consecutive edges. The accepted level drives SW,
// and a one-cycle rise/fall pulse is produced in the same cycle.
module sw_debounce #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SW_RAW,
  output logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  // Terminal count: the edge that sees this value plus a still-differing sync2 accepts.
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] sw_q, sw_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Next-state: synchroniser shift and per-bit qualification counters.
  always_comb begin
    sync1_d = SW_RAW;
    sync2_d = sync1_q;
    sw_d    = sw_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != sw_q[i]) begin
        if (cnt_q[i] != CntMax) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end else begin
          // Level has persisted long enough; accept it and pulse the edge.
          sw_d[i]   = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sw_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sw_q    <= sw_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign SW      = sw_q;
  assign SW_RISE = rise_q;
  assign SW_FALL = fall_q;

endmodule
